// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: frame shifter with lockstep tx/rx shift registers.
// A frame is WIDTH bit periods of DIV clocks, then a one-cycle DONE.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             abort,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_next;
    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    bit_cnt;
    logic             in_idle;
    logic             in_shift;
    logic             in_done;
    logic             accept;
    logic             bit_end;
    logic             last_bit;

    assign in_idle  = (state == S_IDLE);
    assign in_shift = (state == S_SHIFT);
    assign in_done  = (state == S_DONE);

    assign accept   = in_idle && tx_valid && !abort;
    assign bit_end  = in_shift && (div_cnt == DIV_LAST);
    assign last_bit = bit_end && (bit_cnt == BIT_LAST);
    assign rx_next  = {rx_sh[WIDTH-2:0], serial_in};

    assign tx_ready   = in_idle;
    assign busy       = in_shift || in_done;
    assign rx_valid   = in_done;
    assign serial_out = in_shift && tx_sh[WIDTH-1];

    // Next-state decode; abort beats the final bit-end.
    always_comb begin
        state_nx = S_IDLE;
        unique case (1'b1)
            in_idle: begin
                state_nx = accept ? S_SHIFT : S_IDLE;
            end
            in_shift: begin
                if (abort)
                    state_nx = S_IDLE;
                else if (last_bit)
                    state_nx = S_DONE;
                else
                    state_nx = S_SHIFT;
            end
            in_done: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Divider: marks the last cycle of each bit period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (accept || bit_end)
            div_cnt <= '0;
        else if (in_shift)
            div_cnt <= div_cnt + DW'(1);
    end

    // Bit counter: index of the bit currently on the wire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bit_cnt <= '0;
        else if (accept)
            bit_cnt <= '0;
        else if (bit_end)
            bit_cnt <= bit_cnt + CW'(1);
    end

    // Transmit shifter, MSB leaves first, zero fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tx_sh <= '0;
        else if (accept)
            tx_sh <= tx_data;
        else if (bit_end)
            tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
    end

    // Receive shifter, samples serial_in at each bit end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rx_sh <= '0;
        else if (accept)
            rx_sh <= '0;
        else if (bit_end)
            rx_sh <= rx_next;
    end

    // Received word only updates on a completed, unaborted frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rx_data <= '0;
        else if (last_bit && !abort)
            rx_data <= rx_next;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: random and directed frames against a timeline model.
// Second instance covers the DIV=1 corner.
module tb_shift_seq_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int FR = W * D;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         abort;
    logic         sin_drv;
    logic         loop;
    logic         serial_in;
    logic         tx_ready;
    logic         serial_out;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;

    logic [3:0]   d1_data;
    logic         d1_valid;
    logic         d1_abort;
    logic         d1_ready;
    logic         d1_so;
    logic [3:0]   d1_rx;
    logic         d1_rv;
    logic         d1_busy;

    always #5 clk = ~clk;

    assign serial_in = loop ? serial_out : sin_drv;

    shift_seq_ctrl #(.WIDTH(W), .DIV(D)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .abort      (abort),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
    );

    shift_seq_ctrl #(.WIDTH(4), .DIV(1)) u_d1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (d1_data),
        .tx_valid   (d1_valid),
        .tx_ready   (d1_ready),
        .abort      (d1_abort),
        .serial_in  (d1_so),
        .serial_out (d1_so),
        .rx_data    (d1_rx),
        .rx_valid   (d1_rv),
        .busy       (d1_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_gap = 0;
    int acc_n = 0;
    int rv_cyc = 0;
    logic [W-1:0] rxq[$];

    // model: m_t = cycles into frame (0 idle, 1..FR shift, FR+1 done)
    int           m_t = 0;
    logic [W-1:0] m_tx = '0;
    int unsigned  m_acc = 0;
    logic [W-1:0] m_rx = '0;

    function automatic logic m_so();
        if (m_t >= 1 && m_t <= FR)
            return m_tx[W - 1 - (m_t - 1) / D];
        return 1'b0;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic         v;
        logic         a;
        logic         s;
        logic         acc;
        logic [W-1:0] d;
        v = tx_valid;
        a = abort;
        d = tx_data;
        s = loop ? m_so() : sin_drv;
        acc = tx_ready && tx_valid && !abort;
        if (acc) begin
            acc_gap = cyc - last_acc;
            last_acc = cyc;
            acc_n++;
        end
        @(posedge clk);
        cyc++;
        if (m_t == 0) begin
            if (v && !a) begin
                m_tx = d;
                m_acc = 0;
                m_t = 1;
            end
        end else if (m_t <= FR) begin
            if (a) begin
                m_t = 0;
            end else begin
                if (m_t % D == 0)
                    m_acc = (m_acc * 2 + 32'(s)) % (1 << W);
                if (m_t == FR)
                    m_rx = W'(m_acc);
                m_t++;
            end
        end else begin
            m_t = 0;
        end
        #1;
        check("tx_ready", 32'(tx_ready), 32'(m_t == 0));
        check("busy", 32'(busy), 32'(m_t != 0));
        check("serial_out", 32'(serial_out), 32'(m_so()));
        check("rx_valid", 32'(rx_valid), 32'(m_t == FR + 1));
        check("rx_data", 32'(rx_data), 32'(m_rx));
        if (rx_valid) begin
            rxq.push_back(rx_data);
            rv_cyc = cyc;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic wait_rv(string tag, int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            got = rx_valid;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic send(logic [W-1:0] w);
        tx_data = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic check_reset_outs(string tag);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_so"}, 32'(serial_out), 32'd0);
        check({tag, "_rv"}, 32'(rx_valid), 32'd0);
        check({tag, "_rx"}, 32'(rx_data), 32'd0);
    endtask

    initial begin
        int           n0;
        logic [3:0]   e1;
        logic         got;
        reset_n  = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        abort    = 1'b0;
        sin_drv  = 1'b0;
        loop     = 1'b0;
        d1_data  = '0;
        d1_valid = 1'b0;
        d1_abort = 1'b0;
        #12;
        check_reset_outs("rst");
        check("d1_rst_ready", 32'(d1_ready), 32'd1);
        check("d1_rst_busy", 32'(d1_busy), 32'd0);

        // first edge after release accepts; loopback 0xA5
        @(negedge clk);
        reset_n = 1'b1;
        loop = 1'b1;
        rxq.delete();
        send(8'hA5);
        check("first_accept", 32'(acc_n), 32'd1);
        wait_rv("a5_rv", 60);
        check("a5_latency", 32'(rv_cyc - last_acc), 32'd33);
        check("a5_word", 32'(rx_data), 32'hA5);
        run(2);

        // back-to-back with tx_valid held high
        rxq.delete();
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hC3;
        n0 = acc_n;
        for (int i = 0; i < 80 && acc_n == n0; i++)
            step();
        tx_valid = 1'b0;
        check("b2b_gap", 32'(acc_gap), 32'd34);
        wait_rv("b2b_rv", 60);
        run(2);
        check("b2b_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            check("b2b_w0", 32'(rxq[0]), 32'h3C);
            check("b2b_w1", 32'(rxq[1]), 32'hC3);
        end

        // serial_in stuck high, sending zeros
        loop = 1'b0;
        sin_drv = 1'b1;
        rxq.delete();
        send(8'h00);
        wait_rv("ones_rv", 60);
        run(4);
        check("ones_count", 32'(rxq.size()), 32'd1);
        check("ones_word", 32'(rx_data), 32'hFF);

        // abort in third bit period after 0x5A received
        loop = 1'b1;
        send(8'h5A);
        wait_rv("5a_rv", 60);
        run(2);
        rxq.delete();
        send(W'($urandom));
        run(2 * D);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ready", 32'(tx_ready), 32'd1);
        run(40);
        check("abort_no_rv", 32'(rxq.size()), 32'd0);
        check("abort_keep", 32'(rx_data), 32'h5A);

        // abort in idle blocks accept
        tx_valid = 1'b1;
        abort = 1'b1;
        n0 = acc_n;
        step();
        tx_valid = 1'b0;
        abort = 1'b0;
        check("idle_abort", 32'(acc_n), 32'(n0));

        // async reset between edges mid-frame
        send(W'($urandom));
        run(10);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outs("async");
        m_t = 0;
        m_rx = '0;
        #1;
        reset_n = 1'b1;
        rxq.delete();
        run(50);
        check("reset_no_rv", 32'(rxq.size()), 32'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = W'($urandom);
            abort    = ($urandom_range(0, 59) == 0);
            sin_drv  = 1'($urandom);
            loop     = 1'($urandom);
            step();
        end
        tx_valid = 1'b0;
        abort = 1'b0;
        run(FR + 4);

        // DIV=1, WIDTH=4 loopback of 0x9
        e1 = 4'h9;
        d1_data = e1;
        d1_valid = 1'b1;
        @(posedge clk);
        #1;
        d1_valid = 1'b0;
        d1_data = 4'h6;
        for (int k = 0; k < 4; k++) begin
            check("d1_so", 32'(d1_so), 32'(e1[3 - k]));
            check("d1_busy", 32'(d1_busy), 32'd1);
            check("d1_rv_low", 32'(d1_rv), 32'd0);
            @(posedge clk);
            #1;
        end
        check("d1_rv", 32'(d1_rv), 32'd1);
        check("d1_rx", 32'(d1_rx), 32'h9);
        @(posedge clk);
        #1;
        got = d1_rv;
        check("d1_rv_once", 32'(got), 32'd0);
        check("d1_ready", 32'(d1_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
